// File: rtl/tone_sequencer.sv
// Steps the tone organ through up to eight notes, gating each note and then a silent gap.
// Define TONE_SEQ_LOOP_EN to loop the sequence forever instead of stopping after the last note.
module tone_sequencer #(
    parameter int unsigned NOTE_CYCLES = 25000000,
    parameter int unsigned GAP_CYCLES  = 2500000,
    parameter int unsigned NUM_NOTES   = 8
) (
    input  logic       inclk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       dir,
    output logic [2:0] sel,
    output logic       tone_en,
    output logic       busy,
    output logic [2:0] step,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        NOTE,
        GAP
    } state_t;

    localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYCLES - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
    localparam logic [2:0]  STEP_LAST = 3'(NUM_NOTES - 1);
    localparam logic        HAS_GAP   = (GAP_CYCLES != 0);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        dir_q, dir_d;
    logic [2:0]  sel_q, sel_d;
    logic [2:0]  step_q, step_d;
    logic        tone_en_q, tone_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        advance;
    logic [2:0]  next_step;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        sel_d     = sel_q;
        step_d    = step_q;
        tone_en_d = tone_en_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        advance   = 1'b0;
        next_step = step_q + 3'd1;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    dir_d     = dir;
                    step_d    = 3'd0;
                    sel_d     = dir ? 3'd7 : 3'd0;
                    cnt_d     = '0;
                    tone_en_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = NOTE;
                end
            end
            NOTE: begin
                if (stop) begin
                    state_d   = IDLE;
                    tone_en_d = 1'b0;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                end else if (cnt_q == NOTE_LAST) begin
                    cnt_d     = '0;
                    tone_en_d = 1'b0;
                    if (HAS_GAP) begin
                        state_d = GAP;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            GAP: begin
                if (stop) begin
                    state_d   = IDLE;
                    tone_en_d = 1'b0;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared step advance, reached from GAP exit or directly from NOTE when there is no gap.
        if (advance) begin
            if (step_q != STEP_LAST) begin
                step_d    = next_step;
                sel_d     = dir_q ? (3'd7 - next_step) : next_step;
                tone_en_d = 1'b1;
                state_d   = NOTE;
            end else begin
`ifdef TONE_SEQ_LOOP_EN
                step_d    = 3'd0;
                sel_d     = dir_q ? 3'd7 : 3'd0;
                tone_en_d = 1'b1;
                state_d   = NOTE;
                done_d    = 1'b1;
`else
                tone_en_d = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                state_d   = IDLE;
`endif
            end
        end
    end

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            sel_q     <= '0;
            step_q    <= '0;
            tone_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            sel_q     <= sel_d;
            step_q    <= step_d;
            tone_en_q <= tone_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign sel     = sel_q;
    assign tone_en = tone_en_q;
    assign busy    = busy_q;
    assign step    = step_q;
    assign done    = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with NOTE_CYCLES=4, GAP_CYCLES=2, NUM_NOTES=8,
// plus a second instance with GAP_CYCLES=0.
module tb_tone_sequencer;

    logic       inclk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       dir   = 1'b0;
    logic [2:0] sel;
    logic       tone_en;
    logic       busy;
    logic [2:0] step;
    logic       done;

    logic       start2 = 1'b0;
    logic       stop2  = 1'b0;
    logic       dir2   = 1'b0;
    logic [2:0] sel2;
    logic       tone_en2;
    logic       busy2;
    logic [2:0] step2;
    logic       done2;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    tone_sequencer #(.NOTE_CYCLES(4), .GAP_CYCLES(2), .NUM_NOTES(8)) dut (
        .inclk(inclk), .reset(reset), .start(start), .stop(stop), .dir(dir),
        .sel(sel), .tone_en(tone_en), .busy(busy), .step(step), .done(done)
    );

    tone_sequencer #(.NOTE_CYCLES(4), .GAP_CYCLES(0), .NUM_NOTES(8)) dut_nogap (
        .inclk(inclk), .reset(reset), .start(start2), .stop(stop2), .dir(dir2),
        .sel(sel2), .tone_en(tone_en2), .busy(busy2), .step(step2), .done(done2)
    );

    always #5 inclk = ~inclk;

    // Packed observation: {sel, tone_en, busy, step, done}
    function automatic logic [8:0] obs();
        return {sel, tone_en, busy, step, done};
    endfunction

    function automatic logic [8:0] obs2();
        return {sel2, tone_en2, busy2, step2, done2};
    endfunction

    // Expected main-DUT outputs k cycles after the edge that sampled start (k = 0..48).
    function automatic logic [8:0] exp_vec(int k, bit desc);
        logic [2:0] s;
        logic       ton, bsy, dn;
        if (k < 48) begin
            s   = 3'(k / 6);
            ton = (k % 6) < 4;
            bsy = 1'b1;
            dn  = 1'b0;
        end else begin
`ifdef TONE_SEQ_LOOP_EN
            s = 3'd0; ton = 1'b1; bsy = 1'b1; dn = 1'b1;
`else
            s = 3'd7; ton = 1'b0; bsy = 1'b0; dn = 1'b1;
`endif
        end
        return {(desc ? 3'd7 - s : s), ton, bsy, s, dn};
    endfunction

    task automatic tick();
        @(posedge inclk);
        #1;
    endtask

    task automatic apply_reset();
        start = 1'b0; stop = 1'b0; dir = 1'b0;
        start2 = 1'b0; stop2 = 1'b0; dir2 = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        total_cnt++;
        if (obs() !== 9'b0) $display("FAIL reset_state got %b exp %b", obs(), 9'b0);
        else pass_cnt++;
        apply_reset();
        total_cnt++;
        if (obs() !== 9'b0) $display("FAIL idle_after_reset got %b exp %b", obs(), 9'b0);
        else pass_cnt++;
    endtask

    task automatic test_ascending();
        apply_reset();
        start = 1'b1; dir = 1'b0;
        for (int k = 0; k <= 49; k++) begin
            tick();
            if (k == 0) start = 1'b0;
            if (k <= 48) begin
                total_cnt++;
                if (obs() !== exp_vec(k, 1'b0))
                    $display("FAIL ascending k=%0d got %b exp %b", k, obs(), exp_vec(k, 1'b0));
                else pass_cnt++;
            end else begin
                total_cnt++;
                if (done !== 1'b0) $display("FAIL done_one_cycle got %b exp 0", done);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_descending();
        apply_reset();
        start = 1'b1; dir = 1'b1;
        for (int k = 0; k <= 48; k++) begin
            tick();
            if (k == 0) start = 1'b0;
            if (k % 7 == 3) dir = ~dir;
            total_cnt++;
            if (obs() !== exp_vec(k, 1'b1))
                $display("FAIL descending k=%0d got %b exp %b", k, obs(), exp_vec(k, 1'b1));
            else pass_cnt++;
        end
    endtask

    task automatic test_stop_mid_note();
        apply_reset();
        start = 1'b1; dir = 1'b0;
        for (int k = 0; k <= 19; k++) begin
            tick();
            if (k == 0) start = 1'b0;
        end
        total_cnt++;
        if (obs() !== 9'b011_1_1_011_0)
            $display("FAIL before_stop got %b exp %b", obs(), 9'b011_1_1_011_0);
        else pass_cnt++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total_cnt++;
        if (obs() !== 9'b011_0_0_011_0)
            $display("FAIL stop_mid_note got %b exp %b", obs(), 9'b011_0_0_011_0);
        else pass_cnt++;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) begin
                total_cnt++;
                $display("FAIL stop_no_done k=%0d got done=%b busy=%b exp 0 0", k, done, busy);
            end
        end
        total_cnt++;
        if (obs() !== 9'b011_0_0_011_0)
            $display("FAIL stop_hold got %b exp %b", obs(), 9'b011_0_0_011_0);
        else pass_cnt++;
        start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++;
        if (obs() !== exp_vec(0, 1'b0))
            $display("FAIL restart_after_stop got %b exp %b", obs(), exp_vec(0, 1'b0));
        else pass_cnt++;
    endtask

    task automatic test_start_stop_idle();
        apply_reset();
        start = 1'b1; stop = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (obs() !== 9'b0) $display("FAIL start_and_stop_idle got %b exp %b", obs(), 9'b0);
        else pass_cnt++;
        start = 1'b0; stop = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        start = 1'b1; dir = 1'b0;
        for (int k = 0; k <= 48; k++) begin
            tick();
            if (k == 0) start = 1'b0;
            if (k == 8) start = 1'b1;
            if (k == 40) start = 1'b0;
            total_cnt++;
            if (obs() !== exp_vec(k, 1'b0))
                $display("FAIL start_while_busy k=%0d got %b exp %b", k, obs(), exp_vec(k, 1'b0));
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        start = 1'b1; dir = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            tick();
            if (k == 0) start = 1'b0;
        end
        total_cnt++;
        if (obs() !== exp_vec(16, 1'b1))
            $display("FAIL pre_async_gap got %b exp %b", obs(), exp_vec(16, 1'b1));
        else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (obs() !== 9'b0) $display("FAIL async_reset_mid_gap got %b exp %b", obs(), 9'b0);
        else pass_cnt++;
        #1;
        reset = 1'b0;
        tick();
        total_cnt++;
        if (obs() !== 9'b0) $display("FAIL idle_after_async got %b exp %b", obs(), 9'b0);
        else pass_cnt++;
    endtask

    task automatic test_no_gap();
        logic [8:0] e;
        logic [2:0] s;
        apply_reset();
        start2 = 1'b1; dir2 = 1'b0;
        for (int k = 0; k <= 32; k++) begin
            tick();
            if (k == 0) start2 = 1'b0;
            if (k < 32) begin
                s = 3'(k / 4);
                e = {s, 1'b1, 1'b1, s, 1'b0};
            end else begin
`ifdef TONE_SEQ_LOOP_EN
                e = {3'd0, 1'b1, 1'b1, 3'd0, 1'b1};
`else
                e = {3'd7, 1'b0, 1'b0, 3'd7, 1'b1};
`endif
            end
            total_cnt++;
            if (obs2() !== e) $display("FAIL no_gap k=%0d got %b exp %b", k, obs2(), e);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_descending();
        test_stop_mid_note();
        test_start_stop_idle();
        test_back_to_back();
        test_async_reset();
        test_no_gap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
